// File: rtl/btn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : btn_pkg
// Description : Shared constants and helpers for the push-button debouncer.
//               DEF_* values give 10 ms debounce and 1 s long press at 50 MHz.
//               SIM_* values shrink both intervals for fast simulation.
// Revision    : 1.0 - initial release
// ============================================================================
package btn_pkg;

  localparam int DEF_DEB_CYC  = 500000;    // 10 ms @ 50 MHz
  localparam int DEF_LONG_CYC = 50000000;  // 1 s @ 50 MHz
  localparam int SIM_DEB_CYC  = 8;
  localparam int SIM_LONG_CYC = 32;

  // Counter width able to hold terminal-1. Floors at 1 bit so a degenerate
  // terminal value still elaborates.
  function automatic int cnt_width(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_chan.sv
`default_nettype none
// ============================================================================
// Module      : debounce_chan
// Description : One push-button channel: polarity normalisation, 2-FF
//               synchronizer, integrating debounce counter, registered
//               press/release pulses and an optional long-press detector.
//               Long press is built only when BTN_LONGPRESS_EN is defined;
//               otherwise btn_long is tied low.
// Ports       : clk         in  system clock
//               rst         in  synchronous reset, active-low
//               btn_in      in  raw asynchronous pin
//               btn_level   out debounced level, 1 = pressed
//               btn_press   out one-cycle pulse after level rises
//               btn_release out one-cycle pulse after level falls
//               btn_long    out one-cycle pulse after LONG_CYC held cycles
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_chan
  import btn_pkg::*;
#(
  parameter int DEB_CYC  = DEF_DEB_CYC,
  parameter int LONG_CYC = DEF_LONG_CYC,
  parameter bit ACT_LOW  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long
);

  localparam int               CNT_W    = cnt_width(DEB_CYC);
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEB_CYC - 1);

  if (DEB_CYC < 2 || LONG_CYC < 2) begin : g_bad_cfg
    $error("debounce_chan: DEB_CYC and LONG_CYC must both be at least 2");
  end

  logic             norm;
  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             level_dly_q;
  logic             press_q, press_d;
  logic             release_q, release_d;

  // Normalise before synchronizing so the reset value 0 always means released.
  assign norm = ACT_LOW ? ~btn_in : btn_in;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      // Terminal count accepts the new level; cnt_d stays 0 so the counter
      // never wraps and the next transition integrates from scratch.
      if (cnt_q == CNT_TERM) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Edge pulses are taken from the registered level, landing one cycle
    // after btn_level changes.
    press_d   =  level_q & ~level_dly_q;
    release_d = ~level_q &  level_dly_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
    end else begin
      sync1_q     <= norm;
      sync2_q     <= sync1_q;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      press_q     <= press_d;
      release_q   <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef BTN_LONGPRESS_EN
  localparam int                HOLD_W    = cnt_width(LONG_CYC);
  localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(LONG_CYC - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              fired_q, fired_d;
  logic              long_q, long_d;

  always_comb begin
    hold_d  = '0;
    fired_d = 1'b0;
    long_d  = 1'b0;
    if (level_q) begin
      hold_d  = (hold_q == HOLD_TERM) ? hold_q : hold_q + HOLD_W'(1);
      // fired_q holds off repeats until the button is released.
      long_d  = (hold_q == HOLD_TERM) & ~fired_q;
      fired_d = fired_q | long_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hold_q  <= '0;
      fired_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      fired_q <= fired_d;
      long_q  <= long_d;
    end
  end

  assign btn_long = long_q;
`else
  assign btn_long = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : NBTN independent push-button conditioners producing clean
//               debounced levels and single-cycle press / release / long-press
//               events. Long-press logic exists only when BTN_LONGPRESS_EN is
//               defined; otherwise btn_long is constant 0.
// Ports       : clk         in  system clock
//               rst         in  synchronous reset, active-low
//               btn_in      in  [NBTN] raw asynchronous pins
//               btn_level   out [NBTN] debounced level, 1 = pressed
//               btn_press   out [NBTN] one-cycle pulse on accepted press
//               btn_release out [NBTN] one-cycle pulse on accepted release
//               btn_long    out [NBTN] one-cycle pulse on long press
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce
  import btn_pkg::*;
#(
  parameter int NBTN     = 4,
  parameter int DEB_CYC  = DEF_DEB_CYC,
  parameter int LONG_CYC = DEF_LONG_CYC,
  parameter bit ACT_LOW  = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_in,
  output logic [NBTN-1:0] btn_level,
  output logic [NBTN-1:0] btn_press,
  output logic [NBTN-1:0] btn_release,
  output logic [NBTN-1:0] btn_long
);

  for (genvar i = 0; i < NBTN; i++) begin : g_chan
    debounce_chan #(
      .DEB_CYC  (DEB_CYC),
      .LONG_CYC (LONG_CYC),
      .ACT_LOW  (ACT_LOW)
    ) u_chan (
      .clk         (clk),
      .rst         (rst),
      .btn_in      (btn_in[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i])
    );
  end

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debounce
// Description : Self-checking bench for button_debounce (NBTN=4, DEB_CYC=8,
//               LONG_CYC=32, active-low pins). A timestamp-based model states
//               when each output must fire; outputs are compared every cycle
//               and key event times are pinned with literal offsets.
//               Long-press expectations follow BTN_LONGPRESS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce;
  import btn_pkg::*;

  localparam int NBTN = 4;
  localparam int DEB  = SIM_DEB_CYC;
  localparam int LONG = SIM_LONG_CYC;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NBTN-1:0] btn_in = 4'hF;
  logic [NBTN-1:0] btn_level, btn_press, btn_release, btn_long;

  button_debounce #(
    .NBTN     (NBTN),
    .DEB_CYC  (DEB),
    .LONG_CYC (LONG),
    .ACT_LOW  (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  // Edges are numbered from 0. Pin values are seen by the debounce logic two
  // edges after capture; a level flips on the DEB-th consecutive edge that
  // sees the opposite value. Press/release fire one edge after the flip,
  // long press LONG edges after the rising flip while still held.
  int              edge_n      = 0;
  bit              model_valid = 1'b0;
  logic [NBTN-1:0] m_level = '0, m_press = '0, m_rel = '0, m_long = '0;
  logic [NBTN-1:0] m_d1 = '0, m_d2 = '0;
  int              m_mis_from[NBTN] = '{default: -1};
  int              m_rise[NBTN]     = '{default: -1000};
  int              m_fall[NBTN]     = '{default: -1000};

  always @(posedge clk) begin : model
    int              k, mf;
    logic            s, lvl, nl;
    logic [NBTN-1:0] n_level, n_press, n_rel, n_long;
    k = edge_n;
    n_level = '0; n_press = '0; n_rel = '0; n_long = '0;
    if (!rst) begin
      m_level <= '0; m_press <= '0; m_rel <= '0; m_long <= '0;
      m_d1    <= '0; m_d2    <= '0;
      for (int c = 0; c < NBTN; c++) m_mis_from[c] <= -1;
      model_valid <= 1'b1;
    end else begin
      for (int c = 0; c < NBTN; c++) begin
        s   = m_d2[c];
        lvl = m_level[c];
        mf  = m_mis_from[c];
        nl  = lvl;
        if (s == lvl) begin
          mf = -1;
        end else begin
          if (mf < 0) mf = k;
          if (k - mf + 1 >= DEB) begin
            nl = s;
            mf = -1;
          end
        end
        n_level[c] = nl;
        n_press[c] = lvl && (m_rise[c] == k - 1);
        n_rel[c]   = !lvl && (m_fall[c] == k - 1);
`ifdef BTN_LONGPRESS_EN
        n_long[c]  = lvl && (k - m_rise[c] == LONG);
`endif
        m_mis_from[c] <= mf;
        if (nl && !lvl) m_rise[c] <= k;
        if (!nl && lvl) m_fall[c] <= k;
      end
      m_level <= n_level;
      m_press <= n_press;
      m_rel   <= n_rel;
      m_long  <= n_long;
      m_d2    <= m_d1;
      m_d1    <= ~btn_in;
    end
    edge_n <= edge_n + 1;
  end

  // ------------------------------------------------ per-cycle compare
  always @(negedge clk) begin
    if (model_valid) begin
      check("level",   btn_level,   m_level);
      check("press",   btn_press,   m_press);
      check("release", btn_release, m_rel);
      check("long",    btn_long,    m_long);
    end
  end

  // ------------------------------------------------ event recorder
  logic [NBTN-1:0] prev_level = '0;
  int press_cnt[NBTN] = '{default: 0};
  int rel_cnt[NBTN]   = '{default: 0};
  int long_cnt[NBTN]  = '{default: 0};
  int press_at[NBTN]  = '{default: -1};
  int rel_at[NBTN]    = '{default: -1};
  int long_at[NBTN]   = '{default: -1};
  int rise_at[NBTN]   = '{default: -1};

  always @(negedge clk) begin
    if (model_valid) begin
      for (int c = 0; c < NBTN; c++) begin
        if (btn_press[c] === 1'b1)   begin press_cnt[c]++; press_at[c] = edge_n - 1; end
        if (btn_release[c] === 1'b1) begin rel_cnt[c]++;   rel_at[c]   = edge_n - 1; end
        if (btn_long[c] === 1'b1)    begin long_cnt[c]++;  long_at[c]  = edge_n - 1; end
        if (btn_level[c] === 1'b1 && prev_level[c] !== 1'b1) rise_at[c] = edge_n - 1;
      end
      prev_level = btn_level;
    end
  end

  // Waits n falling edges, then settles past the recorder before driving.
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // ------------------------------------------------ stimulus
  initial begin
    int e, r, l0;

    // 1. reset with all buttons released
    rst = 1'b0; btn_in = 4'hF;
    cycles(5);
    check("rst_outputs", {btn_level, btn_press, btn_release, btn_long}, 16'h0);
    rst = 1'b1;
    cycles(20);
    check("idle_outputs", {btn_level, btn_press, btn_release, btn_long}, 16'h0);

    // 2. clean press on ch0
    btn_in[0] = 1'b0; e = edge_n;
    cycles(15);
    check("t2_rise_edge",  rise_at[0],  e + 9);
    check("t2_press_edge", press_at[0], e + 10);
    check("t2_press_cnt",  press_cnt[0], 1);
    check("t2_levels",     btn_level,   4'b0001);

    // 3. bounce on ch1, then hold pressed
    for (int i = 0; i < 10; i++) begin
      btn_in[1] = (i % 2 == 0) ? 1'b0 : 1'b1;
      cycles(3);
    end
    check("t3_no_bounce_evt", press_cnt[1] + rel_cnt[1], 0);
    btn_in[1] = 1'b0; e = edge_n;
    cycles(14);
    check("t3_press_edge", press_at[1], e + 10);
    check("t3_press_cnt",  press_cnt[1], 1);
    check("t3_rel_cnt",    rel_cnt[1],   0);

    // 4. ch0 released while ch2 pressed on the same edge
    btn_in[0] = 1'b1; btn_in[2] = 1'b0; e = edge_n;
    cycles(14);
    check("t4_rel0_edge",   rel_at[0],   e + 10);
    check("t4_press2_edge", press_at[2], e + 10);
    check("t4_rel0_cnt",    rel_cnt[0],  1);
    check("t4_press2_cnt",  press_cnt[2], 1);
    check("t4_levels",      btn_level,   4'b0110);

    // 5. reset in the middle of a ch3 debounce
    btn_in[3] = 1'b0;
    cycles(4);
    rst = 1'b0;
    cycles(3);
    check("t5_press3_none", press_cnt[3], 0);
    rst = 1'b1; r = edge_n;
    cycles(15);
    check("t5_press3_cnt",  press_cnt[3], 1);
    check("t5_press3_edge", press_at[3], r + 10);
    check("t5_press2_cnt",  press_cnt[2], 2);
    check("t5_rel0_cnt",    rel_cnt[0],   1);
    check("t5_levels",      btn_level,    4'b1110);

    // 6. long hold on ch0
    btn_in[0] = 1'b0; e = edge_n; l0 = long_cnt[0];
    cycles(60);
`ifdef BTN_LONGPRESS_EN
    check("t6_long_cnt",  long_cnt[0] - l0, 1);
    check("t6_long_edge", long_at[0], e + 9 + 32);
`else
    check("t6_long_cnt",  long_cnt[0] + long_cnt[1] + long_cnt[2] + long_cnt[3], 0);
`endif

    // release everything
    btn_in = 4'hF;
    cycles(15);
    check("end_levels",  btn_level, 4'b0000);
    check("end_rel_cnt", rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3], 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, failures=%0d", failures);
    $fatal(1);
  end

endmodule
`default_nettype wire
